// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester bundle and fifo write/read-side signals seen by the arbiter.
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 8
) ();

  localparam int unsigned IDX_W = clog2(N_REQ);
  localparam int unsigned CNT_W = clog2(FIFO_DEPTH + 1);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_wr_en;
  logic [IDX_W+WIDTH-1:0] fifo_wr_data;
  logic                   fifo_rd_en;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       credits;
  logic [IDX_W-1:0]       grant_idx;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, fifo_rd_en, fifo_empty,
    output req_ready, fifo_wr_en, fifo_wr_data, credits, grant_idx
  );

  // Producer / fifo side.
  modport slave (
    output req_valid, req_data, fifo_rd_en, fifo_empty,
    input  req_ready, fifo_wr_en, fifo_wr_data, credits, grant_idx
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first valid index at or after i_start, wrapping.
module fifo_wr_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0] i_start,
  output logic             o_found_c,
  output logic [IDX_W-1:0] o_idx_c
);

  // Scan from farthest to nearest so the nearest valid candidate wins.
  always_comb begin
    int unsigned v_pos;
    o_found_c = 1'b0;
    o_idx_c   = '0;
    v_pos     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      v_pos = 32'(i_start) + 32'(k);
      if (v_pos >= N_REQ) v_pos = v_pos - N_REQ;
      if (i_valid[IDX_W'(v_pos)]) begin
        o_found_c = 1'b1;
        o_idx_c   = IDX_W'(v_pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, credit-gated, burst-holding arbiter for a shared fifo write port.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);

  localparam int unsigned IDX_W = clog2(N_REQ);
  localparam int unsigned CNT_W = clog2(FIFO_DEPTH + 1);
  localparam int unsigned BC_W  = clog2(BURST_MAX + 1);

  arb_state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]       r_grant_idx, w_grant_nxt;
  logic [BC_W-1:0]        r_burst_cnt, w_burst_nxt, w_burst_inc;
  logic [CNT_W-1:0]       r_credits;
  logic                   r_wr_en;
  logic [IDX_W+WIDTH-1:0] r_wr_data;

  logic                   w_pick_found;
  logic [IDX_W-1:0]       w_pick_idx;
  logic [IDX_W-1:0]       w_sel, w_sel_inc;
  logic                   w_sel_valid, w_accept, w_rd;
  logic [N_REQ-1:0]       w_ready;
  logic [WIDTH-1:0]       w_payload;

  fifo_wr_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_valid   (bus.req_valid),
    .i_start   (r_rr_ptr),
    .o_found_c (w_pick_found),
    .o_idx_c   (w_pick_idx)
  );

  // Candidate selection, accept decision and one-hot ready; nothing accepted while in reset.
  always_comb begin
    w_sel       = (r_state == HOLD) ? r_grant_idx : w_pick_idx;
    w_sel_valid = (r_state == HOLD) ? bus.req_valid[r_grant_idx] : w_pick_found;
    w_accept    = w_sel_valid & (r_credits != '0) & ~rst;
    w_rd        = bus.fifo_rd_en & ~bus.fifo_empty;
    w_sel_inc   = (w_sel == IDX_W'(N_REQ - 1)) ? '0 : w_sel + IDX_W'(1);
    w_ready     = '0;
    if (w_accept) w_ready[w_sel] = 1'b1;
  end

  // Payload mux for the selected requester.
  always_comb begin
    w_payload = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_sel == IDX_W'(i)) w_payload = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state logic: pick in ARB, stick with one requester for up to BURST_MAX beats in HOLD.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_grant_nxt  = r_grant_idx;
    w_burst_nxt  = r_burst_cnt;
    w_burst_inc  = r_burst_cnt + BC_W'(1);
    case (r_state)
      ARB: begin
        if (w_accept) begin
          w_grant_nxt = w_sel;
          w_burst_nxt = BC_W'(1);
          if (BURST_MAX > 1) w_state_nxt  = HOLD;
          else               w_rr_ptr_nxt = w_sel_inc;
        end
      end
      HOLD: begin
        if (w_accept) begin
          w_burst_nxt = w_burst_inc;
          if (w_burst_inc == BC_W'(BURST_MAX)) begin
            w_state_nxt  = ARB;
            w_rr_ptr_nxt = w_sel_inc;
          end
        end else if (!w_sel_valid) begin
          w_state_nxt  = ARB;
          w_rr_ptr_nxt = w_sel_inc;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // FSM, pointer and burst registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_grant_idx <= w_grant_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  // Free-slot credits: spend on accept, refund on a real fifo read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= CNT_W'(FIFO_DEPTH);
    end else if (w_accept && !w_rd) begin
      r_credits <= r_credits - CNT_W'(1);
    end else if (!w_accept && w_rd) begin
      r_credits <= r_credits + CNT_W'(1);
    end
  end

  // Registered fifo write of the accepted beat, tagged with its source index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) r_wr_data <= {w_sel, w_payload};
    end
  end

  a_credits_max : assert property (@(posedge clk) disable iff (rst)
                                   r_credits <= CNT_W'(FIFO_DEPTH));

  assign bus.req_ready    = w_ready;
  assign bus.fifo_wr_en   = r_wr_en;
  assign bus.fifo_wr_data = r_wr_data;
  assign bus.credits      = r_credits;
  assign bus.grant_idx    = r_grant_idx;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: scenario tasks against a queue-based fifo/arbitration model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int B  = 4;
  localparam int IW = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W), .FIFO_DEPTH(D)) u_if ();

  fifo_wr_arbiter #(
    .N_REQ(N), .WIDTH(W), .FIFO_DEPTH(D), .BURST_MAX(B)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  int n_vec = 0;
  int n_err = 0;

  // Stimulus state
  logic [N-1:0] rq_valid;
  logic [W-1:0] rq_data [N];
  logic         rd;

  // Reference model: fifo contents, in-flight write, ownership of the write port
  logic [IW+W-1:0] fq [$];
  logic            m_wr_en;
  logic [IW+W-1:0] m_wr_data;
  int              m_ptr, m_owner, m_beats, m_sel;
  bit              m_acc;
  logic [IW-1:0]   exp_grant;
  logic [N-1:0]    exp_ready;
  logic [CW-1:0]   exp_credits;
  int              acc_log [$];

  task automatic drive();
    u_if.req_valid = rq_valid;
    for (int i = 0; i < N; i++) u_if.req_data[i*W +: W] = rq_data[i];
    u_if.fifo_rd_en = rd;
    u_if.fifo_empty = (fq.size() == 0);
  endtask

  // Expected combinational view of the current cycle.
  task automatic predict();
    int cr;
    drive();
    #1;
    cr = D - fq.size() - (m_wr_en ? 1 : 0);
    exp_credits = CW'(cr);
    m_sel = -1;
    if (m_owner >= 0) begin
      if (rq_valid[m_owner]) m_sel = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_sel < 0 && rq_valid[(m_ptr + k) % N]) m_sel = (m_ptr + k) % N;
      end
    end
    m_acc = (m_sel >= 0) && (cr > 0);
    exp_ready = '0;
    if (m_acc) exp_ready[m_sel] = 1'b1;
  endtask

  // Clock edge: update fifo contents, in-flight write and port ownership.
  task automatic tick();
    bit pop;
    @(posedge clk);
    pop = rd && (fq.size() > 0);
    if (pop) void'(fq.pop_front());
    if (m_wr_en) begin
      n_vec++;
      if (fq.size() >= D) begin
        n_err++;
        $display("FAIL fifo_overflow: write into fifo holding %0d, limit %0d", fq.size(), D);
      end
      fq.push_back(m_wr_data);
    end
    m_wr_en = m_acc;
    if (m_acc) begin
      m_wr_data = {IW'(m_sel), rq_data[m_sel]};
      exp_grant = IW'(m_sel);
      acc_log.push_back(m_sel);
    end
    if (m_owner >= 0 && !rq_valid[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (m_acc) begin
      if (m_owner < 0) begin
        m_owner = m_sel;
        m_beats = 0;
      end
      m_beats++;
      if (m_beats == B) begin
        m_ptr   = (m_sel + 1) % N;
        m_owner = -1;
      end
    end
    @(negedge clk);
  endtask

  // Refill requesters that were just served or idle, with probability pv percent.
  task automatic gen_req(input int pv);
    for (int i = 0; i < N; i++) begin
      if (!rq_valid[i] || (m_acc && m_sel == i)) begin
        rq_valid[i] = ($urandom_range(99) < pv);
        rq_data[i]  = W'($urandom);
      end
    end
  endtask

  task automatic model_clear();
    fq.delete();
    acc_log.delete();
    m_wr_en = 1'b0; m_wr_data = '0;
    m_ptr = 0; m_owner = -1; m_beats = 0; m_sel = -1; m_acc = 1'b0;
    exp_grant = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq_valid = '0;
    rd = 1'b0;
    model_clear();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rq_valid = '1;
    for (int i = 0; i < N; i++) rq_data[i] = W'($urandom);
    rd = 1'b0;
    model_clear();
    drive();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec += 5;
    if (u_if.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en got %b exp 0", u_if.fifo_wr_en); end
    if (u_if.fifo_wr_data !== '0) begin n_err++; $display("FAIL rst_wr_data got %h exp 0", u_if.fifo_wr_data); end
    if (u_if.credits !== CW'(D)) begin n_err++; $display("FAIL rst_credits got %0d exp %0d", u_if.credits, D); end
    if (u_if.grant_idx !== '0) begin n_err++; $display("FAIL rst_grant got %0d exp 0", u_if.grant_idx); end
    if (u_if.req_ready !== '0) begin n_err++; $display("FAIL rst_ready got %b exp 0000", u_if.req_ready); end
    @(negedge clk);
    rst = 1'b0;
    predict();
    n_vec++;
    if (u_if.req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_first_ready got %b exp 0001", u_if.req_ready); end
    tick();
  endtask

  // All valid, no consumer: 0 x4, 1 x4, then credits exhausted.
  task automatic test_fill();
    do_reset();
    rq_valid = '1;
    for (int c = 0; c < 12; c++) begin
      predict();
      n_vec += 3;
      if (u_if.req_ready !== exp_ready) begin n_err++; $display("FAIL fill_ready cyc %0d got %b exp %b", c, u_if.req_ready, exp_ready); end
      if (u_if.credits !== exp_credits) begin n_err++; $display("FAIL fill_credits cyc %0d got %0d exp %0d", c, u_if.credits, exp_credits); end
      if (u_if.fifo_wr_en !== m_wr_en) begin n_err++; $display("FAIL fill_wr_en cyc %0d got %b exp %b", c, u_if.fifo_wr_en, m_wr_en); end
      if (m_wr_en) begin
        n_vec++;
        if (u_if.fifo_wr_data !== m_wr_data) begin n_err++; $display("FAIL fill_wr_data cyc %0d got %h exp %h", c, u_if.fifo_wr_data, m_wr_data); end
      end
      tick();
      gen_req(100);
    end
    predict();
    n_vec += 3;
    if (acc_log.size() != 8) begin n_err++; $display("FAIL fill_count got %0d exp 8", acc_log.size()); end
    else for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (acc_log[k] != k / 4) begin n_err++; $display("FAIL fill_order beat %0d got %0d exp %0d", k, acc_log[k], k / 4); end
    end
    if (u_if.credits !== '0) begin n_err++; $display("FAIL fill_credits_zero got %0d exp 0", u_if.credits); end
    if (u_if.req_ready !== '0) begin n_err++; $display("FAIL fill_ready_zero got %b exp 0000", u_if.req_ready); end
  endtask

  // All valid, consumer drains continuously: strict 4-beat rotation, no stall.
  task automatic test_stream();
    do_reset();
    rq_valid = '1;
    for (int c = 0; c < 24; c++) begin
      rd = (fq.size() > 0);
      predict();
      n_vec += 3;
      if (u_if.req_ready !== exp_ready) begin n_err++; $display("FAIL stream_ready cyc %0d got %b exp %b", c, u_if.req_ready, exp_ready); end
      if (u_if.credits !== exp_credits) begin n_err++; $display("FAIL stream_credits cyc %0d got %0d exp %0d", c, u_if.credits, exp_credits); end
      if (u_if.fifo_wr_en !== m_wr_en) begin n_err++; $display("FAIL stream_wr_en cyc %0d got %b exp %b", c, u_if.fifo_wr_en, m_wr_en); end
      if (m_wr_en) begin
        n_vec++;
        if (u_if.fifo_wr_data !== m_wr_data) begin n_err++; $display("FAIL stream_tag_data cyc %0d got %h exp %h", c, u_if.fifo_wr_data, m_wr_data); end
      end
      tick();
      gen_req(100);
    end
    n_vec++;
    if (acc_log.size() != 24) begin n_err++; $display("FAIL stream_count got %0d exp 24", acc_log.size()); end
    else for (int k = 0; k < 24; k++) begin
      n_vec++;
      if (acc_log[k] != (k / 4) % 4) begin n_err++; $display("FAIL stream_order beat %0d got %0d exp %0d", k, acc_log[k], (k / 4) % 4); end
    end
    rd = 1'b0;
  endtask

  // Lone requester 2 drops after 3 beats; pointer moves past it to 3.
  task automatic test_partial_burst();
    int  n2;
    bit  dropped;
    n2 = 0;
    dropped = 1'b0;
    do_reset();
    rq_valid = 4'b0100;
    for (int i = 0; i < N; i++) rq_data[i] = W'($urandom);
    for (int c = 0; c < 8; c++) begin
      predict();
      n_vec += 2;
      if (u_if.req_ready !== exp_ready) begin n_err++; $display("FAIL partial_ready cyc %0d got %b exp %b", c, u_if.req_ready, exp_ready); end
      if (u_if.fifo_wr_en !== m_wr_en) begin n_err++; $display("FAIL partial_wr_en cyc %0d got %b exp %b", c, u_if.fifo_wr_en, m_wr_en); end
      tick();
      if (m_acc && m_sel == 2) n2++;
      if (n2 == 3 && !dropped) begin
        rq_valid = 4'b1001;
        dropped  = 1'b1;
      end
    end
    n_vec++;
    if (acc_log.size() < 4) begin n_err++; $display("FAIL partial_count got %0d exp >=4", acc_log.size()); end
    else begin
      n_vec++;
      if (acc_log[3] != 3) begin n_err++; $display("FAIL partial_next_grant got %0d exp 3", acc_log[3]); end
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (acc_log[k] != 2) begin n_err++; $display("FAIL partial_burst beat %0d got %0d exp 2", k, acc_log[k]); end
      end
    end
  endtask

  // credits==1 with simultaneous accept and read: no stall, credits hold at 1.
  task automatic test_credit_one();
    do_reset();
    rq_valid = 4'b0001;
    rq_data[0] = W'($urandom);
    for (int c = 0; c < 7; c++) begin
      predict();
      tick();
      gen_req(100);
      rq_valid[3:1] = '0;
    end
    rd = 1'b1;
    for (int c = 0; c < 4; c++) begin
      predict();
      n_vec += 3;
      if (u_if.credits !== CW'(1)) begin n_err++; $display("FAIL credit1_value cyc %0d got %0d exp 1", c, u_if.credits); end
      if (u_if.req_ready !== 4'b0001) begin n_err++; $display("FAIL credit1_ready cyc %0d got %b exp 0001", c, u_if.req_ready); end
      if (u_if.credits !== exp_credits) begin n_err++; $display("FAIL credit1_model cyc %0d got %0d exp %0d", c, u_if.credits, exp_credits); end
      tick();
      gen_req(100);
      rq_valid[3:1] = '0;
    end
    rd = 1'b0;
  endtask

  // Asynchronous reset with a beat in flight mid-burst.
  task automatic test_async_reset();
    do_reset();
    rq_valid = '1;
    for (int i = 0; i < N; i++) rq_data[i] = W'($urandom);
    for (int c = 0; c < 2; c++) begin
      predict();
      tick();
      gen_req(100);
    end
    n_vec++;
    if (u_if.fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL arst_pre_wr_en got %b exp 1", u_if.fifo_wr_en); end
    #2;
    rst = 1'b1;
    #1;
    n_vec += 4;
    if (u_if.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL arst_wr_en got %b exp 0", u_if.fifo_wr_en); end
    if (u_if.fifo_wr_data !== '0) begin n_err++; $display("FAIL arst_wr_data got %h exp 0", u_if.fifo_wr_data); end
    if (u_if.credits !== CW'(D)) begin n_err++; $display("FAIL arst_credits got %0d exp %0d", u_if.credits, D); end
    if (u_if.req_ready !== '0) begin n_err++; $display("FAIL arst_ready got %b exp 0000", u_if.req_ready); end
    do_reset();
    rq_valid = '1;
    for (int c = 0; c < 4; c++) begin
      predict();
      n_vec++;
      if (u_if.req_ready !== exp_ready) begin n_err++; $display("FAIL arst_post_ready cyc %0d got %b exp %b", c, u_if.req_ready, exp_ready); end
      tick();
      gen_req(100);
    end
    n_vec++;
    if (acc_log.size() == 0 || acc_log[0] != 0) begin
      n_err++;
      $display("FAIL arst_restart got %0d exp 0", (acc_log.size() == 0) ? -1 : acc_log[0]);
    end
  endtask

  // Read strobe against an empty fifo never refunds a credit.
  task automatic test_rd_empty();
    do_reset();
    rq_valid = '0;
    rd = 1'b1;
    for (int c = 0; c < 4; c++) begin
      predict();
      n_vec++;
      if (u_if.credits !== CW'(D)) begin n_err++; $display("FAIL rd_empty_credits cyc %0d got %0d exp %0d", c, u_if.credits, D); end
      tick();
    end
    rd = 1'b0;
  endtask

  // Random valids and consumer reads against the model.
  task automatic test_random();
    do_reset();
    for (int i = 0; i < N; i++) begin
      rq_valid[i] = ($urandom_range(99) < 60);
      rq_data[i]  = W'($urandom);
    end
    for (int c = 0; c < 400; c++) begin
      rd = ($urandom_range(99) < 45);
      predict();
      n_vec += 4;
      if (u_if.req_ready !== exp_ready) begin n_err++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, u_if.req_ready, exp_ready); end
      if (u_if.credits !== exp_credits) begin n_err++; $display("FAIL rand_credits cyc %0d got %0d exp %0d", c, u_if.credits, exp_credits); end
      if (u_if.fifo_wr_en !== m_wr_en) begin n_err++; $display("FAIL rand_wr_en cyc %0d got %b exp %b", c, u_if.fifo_wr_en, m_wr_en); end
      if (u_if.grant_idx !== exp_grant) begin n_err++; $display("FAIL rand_grant cyc %0d got %0d exp %0d", c, u_if.grant_idx, exp_grant); end
      if (m_wr_en) begin
        n_vec++;
        if (u_if.fifo_wr_data !== m_wr_data) begin n_err++; $display("FAIL rand_wr_data cyc %0d got %h exp %h", c, u_if.fifo_wr_data, m_wr_data); end
      end
      tick();
      gen_req(60);
    end
    rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rq_valid = '0;
    rd = 1'b0;
    for (int i = 0; i < N; i++) rq_data[i] = '0;
    model_clear();
    drive();
    @(negedge clk);
    test_reset();
    test_fill();
    test_stream();
    test_partial_burst();
    test_credit_one();
    test_async_reset();
    test_rd_empty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
